// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, port identifiers and the write-back entry payload for the
// register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned CNT_W    = 16;

  localparam logic WB_PORT_ALU = 1'b0;
  localparam logic WB_PORT_MEM = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request ports, register-file write port and status outputs.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                alu_valid;
  logic                alu_ready;
  logic [ADDR_W-1:0]   alu_reg;
  logic [DATA_W-1:0]   alu_data;
  logic                mem_valid;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_reg;
  logic [DATA_W-1:0]   mem_data;
  logic                rf_reg_write;
  logic [ADDR_W-1:0]   rf_write_register;
  logic [DATA_W-1:0]   rf_write_data;
  logic [NUM_REGS-1:0] pending_mask;
  logic [CNT_W-1:0]    conflict_cnt;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, rf_reg_write, rf_write_register,
           rf_write_data, pending_mask, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, rf_reg_write, rf_write_register,
           rf_write_data, pending_mask, conflict_cnt
  );

endinterface

// File: rtl/regfile_wb_arbiter_buffer.sv
// One-entry write-back holding buffer; a load wins over a clear on the same edge.
module wb_hold_buffer
  import regfile_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_reg,
  input  logic [DATA_W-1:0] load_data,
  output wb_entry_t         entry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
    end else if (load) begin
      entry <= '{valid: 1'b1, rd: load_reg, data: load_data};
    end else if (clear) begin
      entry.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and memory write-back
// paths: round-robin grant with an oldest-first override on same-register writes.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_arbiter_if.slave bus
);

  wb_entry_t           alu_q;
  wb_entry_t           mem_q;
  logic                grant_alu;
  logic                grant_mem;
  logic                sel_mem;
  logic                both_valid;
  logic                same_reg;
  logic                alu_ready_c;
  logic                mem_ready_c;
  logic                alu_load;
  logic                mem_load;
  logic                rr_ptr;
  logic                rr_ptr_d;
  logic                older_is_1;
  logic                older_is_1_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [NUM_REGS-1:0] pend_c;
  logic                we_c;
  logic [ADDR_W-1:0]   wreg_c;
  logic [DATA_W-1:0]   wdata_c;

  wb_hold_buffer u_alu_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (alu_load),
    .clear     (grant_alu),
    .load_reg  (bus.alu_reg),
    .load_data (bus.alu_data),
    .entry     (alu_q)
  );

  wb_hold_buffer u_mem_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mem_load),
    .clear     (grant_mem),
    .load_reg  (bus.mem_reg),
    .load_data (bus.mem_data),
    .entry     (mem_q)
  );

  // Grant depends only on buffered state, never on the incoming requests.
  always_comb begin
    both_valid = alu_q.valid & mem_q.valid;
    same_reg   = (alu_q.rd == mem_q.rd);
    sel_mem    = 1'b0;
    grant_alu  = alu_q.valid;
    grant_mem  = mem_q.valid;
    if (both_valid) begin
      sel_mem   = same_reg ? older_is_1 : (rr_ptr == WB_PORT_MEM);
      grant_mem = sel_mem;
      grant_alu = !sel_mem;
    end
  end

  assign alu_ready_c = !alu_q.valid | grant_alu;
  assign mem_ready_c = !mem_q.valid | grant_mem;
  assign alu_load    = bus.alu_valid & alu_ready_c;
  assign mem_load    = bus.mem_valid & mem_ready_c;

  // Next state for the round-robin pointer, age bit and conflict counter.
  always_comb begin
    rr_ptr_d     = rr_ptr;
    older_is_1_d = older_is_1;
    cnt_d        = cnt_q;
    if (both_valid && !same_reg) begin
      rr_ptr_d = !rr_ptr;
    end
    if (alu_load && mem_load) begin
      older_is_1_d = 1'b1;
    end else if (alu_load) begin
      older_is_1_d = mem_q.valid & !grant_mem;
    end else if (mem_load) begin
      older_is_1_d = !(alu_q.valid & !grant_alu);
    end
    if (both_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= WB_PORT_ALU;
      older_is_1 <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rr_ptr     <= rr_ptr_d;
      older_is_1 <= older_is_1_d;
      cnt_q      <= cnt_d;
    end
  end

  // Register-file write port and pending-register mask.
  always_comb begin
    we_c    = 1'b0;
    wreg_c  = '0;
    wdata_c = '0;
    pend_c  = '0;
    if (grant_alu) begin
      we_c    = 1'b1;
      wreg_c  = alu_q.rd;
      wdata_c = alu_q.data;
    end else if (grant_mem) begin
      we_c    = 1'b1;
      wreg_c  = mem_q.rd;
      wdata_c = mem_q.data;
    end
    if (alu_q.valid) begin
      pend_c[alu_q.rd] = 1'b1;
    end
    if (mem_q.valid) begin
      pend_c[mem_q.rd] = 1'b1;
    end
  end

  assign bus.alu_ready         = alu_ready_c;
  assign bus.mem_ready         = mem_ready_c;
  assign bus.rf_reg_write      = we_c;
  assign bus.rf_write_register = wreg_c;
  assign bus.rf_write_data     = wdata_c;
  assign bus.pending_mask      = pend_c;
  assign bus.conflict_cnt      = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter: table of per-cycle stimulus and
// expected post-edge outputs, plus reset-abort and counter-saturation sequences.
module tb_regfile_wb_arbiter;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        ardy;
    logic        mrdy;
    logic [31:0] pend;
    logic [15:0] cnt;
  } vec_t;

  localparam int NVEC = 23;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  vec_t vecs [NVEC];

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md,
                              input logic we, input logic [4:0] wr, input logic [31:0] wd,
                              input logic ardy, input logic mrdy,
                              input logic [31:0] pend, input logic [15:0] cnt);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.we = we; v.wr = wr; v.wd = wd; v.ardy = ardy; v.mrdy = mrdy;
    v.pend = pend; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // stimulus (alu v/reg/data, mem v/reg/data) -> outputs after the edge
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,          1, 5, 32'hDEADBEEF, 1, 1, 32'h020, 0);
    vecs[1]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 0,            1, 1, 32'h000, 0);
    vecs[2]  = mk(1, 3, 32'hA1,       1, 7, 32'hB1,     1, 3, 32'hA1,       1, 0, 32'h088, 0);
    vecs[3]  = mk(1, 3, 32'hA2,       1, 7, 32'hB2,     1, 7, 32'hB1,       0, 1, 32'h088, 1);
    vecs[4]  = mk(1, 3, 32'hA3,       1, 7, 32'hB3,     1, 3, 32'hA2,       1, 0, 32'h088, 2);
    vecs[5]  = mk(1, 3, 32'hA4,       1, 7, 32'hB4,     1, 7, 32'hB3,       0, 1, 32'h088, 3);
    vecs[6]  = mk(1, 3, 32'hA5,       1, 7, 32'hB5,     1, 3, 32'hA4,       1, 0, 32'h088, 4);
    vecs[7]  = mk(0, 0, 0,            0, 0, 0,          1, 7, 32'hB5,       1, 1, 32'h080, 5);
    vecs[8]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 0,            1, 1, 32'h000, 5);
    vecs[9]  = mk(0, 0, 0,            1, 9, 32'h1,      1, 9, 32'h1,        1, 1, 32'h200, 5);
    vecs[10] = mk(1, 9, 32'h2,        0, 0, 0,          1, 9, 32'h2,        1, 1, 32'h200, 5);
    vecs[11] = mk(0, 0, 0,            0, 0, 0,          0, 0, 0,            1, 1, 32'h000, 5);
    vecs[12] = mk(1, 9, 32'h22,       1, 9, 32'h11,     1, 9, 32'h11,       0, 1, 32'h200, 5);
    vecs[13] = mk(0, 0, 0,            0, 0, 0,          1, 9, 32'h22,       1, 1, 32'h200, 6);
    vecs[14] = mk(0, 0, 0,            0, 0, 0,          0, 0, 0,            1, 1, 32'h000, 6);
    vecs[15] = mk(1, 2, 32'hA2A2,     1, 9, 32'h9999,   1, 9, 32'h9999,     0, 1, 32'h204, 6);
    vecs[16] = mk(0, 0, 0,            1, 2, 32'h2222,   1, 2, 32'hA2A2,     1, 0, 32'h004, 7);
    vecs[17] = mk(1, 2, 32'h5555,     0, 0, 0,          1, 2, 32'h2222,     0, 1, 32'h004, 8);
    vecs[18] = mk(0, 0, 0,            0, 0, 0,          1, 2, 32'h5555,     1, 1, 32'h004, 9);
    vecs[19] = mk(0, 0, 0,            0, 0, 0,          0, 0, 0,            1, 1, 32'h000, 9);
    vecs[20] = mk(1, 1, 32'h10,       1, 6, 32'h60,     1, 1, 32'h10,       1, 0, 32'h042, 9);
    vecs[21] = mk(0, 0, 0,            1, 6, 32'h60,     1, 6, 32'h60,       1, 1, 32'h040, 10);
    vecs[22] = mk(0, 0, 0,            0, 0, 0,          0, 0, 0,            1, 1, 32'h000, 10);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("reset.we",    32'(bus.rf_reg_write), 32'h0);
    check("reset.wreg",  32'(bus.rf_write_register), 32'h0);
    check("reset.wdata", bus.rf_write_data, 32'h0);
    check("reset.pend",  bus.pending_mask, 32'h0);
    check("reset.ardy",  32'(bus.alu_ready), 32'h1);
    check("reset.mrdy",  32'(bus.mem_ready), 32'h1);
    check("reset.cnt",   32'(bus.conflict_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.we", i),    32'(bus.rf_reg_write), 32'(vecs[i].we));
      check($sformatf("v%0d.wreg", i),  32'(bus.rf_write_register), 32'(vecs[i].wr));
      check($sformatf("v%0d.wdata", i), bus.rf_write_data, vecs[i].wd);
      check($sformatf("v%0d.ardy", i),  32'(bus.alu_ready), 32'(vecs[i].ardy));
      check($sformatf("v%0d.mrdy", i),  32'(bus.mem_ready), 32'(vecs[i].mrdy));
      check($sformatf("v%0d.pend", i),  bus.pending_mask, vecs[i].pend);
      check($sformatf("v%0d.cnt", i),   32'(bus.conflict_cnt), 32'(vecs[i].cnt));
    end

    // Reset pulse between edges while both buffers hold writes.
    @(negedge clk);
    drive(1, 11, 32'hB0B0, 1, 12, 32'hC0C0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    check("rstmid.pre_we",   32'(bus.rf_reg_write), 32'h1);
    check("rstmid.pre_pend", bus.pending_mask, 32'h1800);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid.we",   32'(bus.rf_reg_write), 32'h0);
    check("rstmid.pend", bus.pending_mask, 32'h0);
    check("rstmid.ardy", 32'(bus.alu_ready), 32'h1);
    check("rstmid.mrdy", 32'(bus.mem_ready), 32'h1);
    check("rstmid.cnt",  32'(bus.conflict_cnt), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rstmid.stale_we%0d", i),   32'(bus.rf_reg_write), 32'h0);
      check($sformatf("rstmid.stale_pend%0d", i), bus.pending_mask, 32'h0);
    end

    // Continuous contention until the conflict counter saturates.
    @(negedge clk);
    drive(1, 3, 32'h1, 1, 7, 32'h2);
    repeat (65535) @(posedge clk);
    #1;
    check("sat.below", 32'(bus.conflict_cnt), 32'hFFFE);
    @(posedge clk);
    #1;
    check("sat.reach", 32'(bus.conflict_cnt), 32'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    check("sat.hold", 32'(bus.conflict_cnt), 32'hFFFF);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("sat.drain_we", 32'(bus.rf_reg_write), 32'h0);
    check("sat.drain_cnt", 32'(bus.conflict_cnt), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two write-back requesters: port 0 = ALU result, port 1 = load/memory result.
- Each port has a one-entry holding buffer with a valid/ready handshake.
- Arbitration is round-robin, with a same-destination ordering override so the older write reaches the file first.
- Exports a pending-write mask that decode uses for hazard stalls.

Parameters:
- DATA_W, 32, write data width; matches the register file size.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers; width of the pending mask.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU buffer can accept this cycle.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU write data.
- mem_valid  in  1  memory write-back request.
- mem_ready  out  1  memory buffer can accept this cycle.
- mem_reg  in  ADDR_W  memory destination register.
- mem_data  in  DATA_W  memory write data.
- rf_reg_write  out  1  write strobe to the register file.
- rf_write_register  out  ADDR_W  register file write index.
- rf_write_data  out  DATA_W  register file write data.
- pending_mask  out  NUM_REGS  bit r = 1 while a buffered write targets register r.
- conflict_cnt  out  16  count of cycles in which both buffers were valid.

Behaviour:
- Reset (async, rst_n=0):
  - Both buffers invalid; rr_ptr=0; older_is_1=0; conflict_cnt=0.
  - Outputs: rf_reg_write=0, rf_write_register=0, rf_write_data=0, pending_mask=0, alu_ready=1, mem_ready=1.
  - Asserting reset mid-operation discards buffered writes with no partial strobe. A release is sampled at the next clk edge.
- Buffers: each holds {valid, reg, data}. A handshake fires on a rising edge when valid&ready, loading the buffer.
- Ready: port ready = !buf_valid | grant_to_that_port (same-cycle free). Ready does not depend on the same port's valid.
- Grant, combinational from buffer state only:
  - Neither valid: no grant, rf_reg_write=0, rf_write_register/rf_write_data hold 0.
  - One valid: grant it.
  - Both valid with different regs: grant port rr_ptr. On the edge, rr_ptr toggles to the other port.
  - Both valid with the same reg: grant the older buffer (older_is_1 selects). rr_ptr is unchanged.
- Outputs: rf_reg_write=1 with rf_write_register/rf_write_data driven from the granted buffer, combinationally. The register file samples them on the edge, and the granted buffer clears on that same edge unless it is reloaded.
- Latency: a request accepted at edge N is written at edge N+1 at the earliest, and at edge N+2 at the latest.
- Age tracking for older_is_1:
  - A buffer loaded while the other stays valid becomes the younger.
  - Both loaded on the same edge: mem (port 1) is older, i.e. older_is_1=1.
  - A load while the other buffer is empty: the other is deemed younger.
- Simultaneous grant-and-reload of the same port: the new entry becomes younger than any valid other buffer.
- pending_mask: OR of one-hot decodes of valid buffers' reg, registered view of buffer state. It clears the edge after the write fires.
- conflict_cnt: increments each edge where both buffers are valid. It saturates at 16'hFFFF and does not wrap.
- Register 0 gets no special treatment; it is written like any other.
- No write is ever dropped or duplicated; every accepted handshake produces exactly one rf_reg_write cycle.

Decomposition:
- Shared package:
  - WB_PORT_ALU=0, WB_PORT_MEM=1.
  - DATA_W/ADDR_W/NUM_REGS defaults.
  - typedef wb_entry_t {valid, reg[ADDR_W], data[DATA_W]}.
- Sub-module: wb_hold_buffer. One-entry valid/ready buffer, instantiated twice. It exposes entry, load, and clear.
- Grant, age, and counter logic stay in the top.

Test Plan:
- Single ALU write: alu_valid=1, reg=5, data=32'hDEAD_BEEF for one cycle -> next cycle rf_reg_write=1, rf_write_register=5, rf_write_data=DEADBEEF, pending_mask[5]=1; one cycle later pending_mask=0 and rf_reg_write=0.
- Contention, different regs: both ports request every cycle (ALU reg 3, mem reg 7) for 6 cycles from reset -> grants alternate ALU, mem, ALU, …; each port's ready is low every other cycle; conflict_cnt increments once per both-valid cycle.
- Same-register ordering: mem accepts reg 9 = 1 at edge N, ALU accepts reg 9 = 2 at edge N+1 -> writes reach the file mem (1) then ALU (2); final value 2. Repeat with both accepted on the same edge -> mem first.
- Backpressure: hold mem_valid high while ALU is granted and mem's buffer is full -> mem_ready=0; mem_reg/mem_data held constant are written exactly once after release.
- Reset mid-operation: both buffers full, rst_n low for 1 ns between edges -> rf_reg_write=0 and pending_mask=0 immediately; after release no stale write appears.
- Counter saturation: force 65 540 both-valid cycles -> conflict_cnt=16'hFFFF and stays there.
